// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus layouts for the MEM stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 39;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_B    = 3'b001,
        LD_H    = 3'b010,
        LD_W    = 3'b011,
        LD_BU   = 3'b101,
        LD_HU   = 3'b110
    } ld_op_e;

    typedef struct packed {
        logic        mem_req;
        logic [2:0]  ld_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        we_valid;
        logic [4:0]  dest;
        logic        load_pending;
        logic [31:0] final_result;
    } ms_to_ds_t;

endpackage

// File: rtl/mem_stage_if.sv
// EXE->MEM, data-SRAM response, MEM->WB and MEM->ID signals of the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd,
    output logic [31:0] load_result
);

    function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
        return 32'(v);
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rd[31:16] : rd[15:0];
        case (ld_op)
            LD_B:    load_result = sext8(byte_sel);
            LD_BU:   load_result = {24'd0, byte_sel};
            LD_H:    load_result = sext16(half_sel);
            LD_HU:   load_result = {16'd0, half_sel};
            default: load_result = rd;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response, aligns load data.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    es_to_ms_t   es_in;
    es_to_ms_t   bus_p0;
    logic        vld_p0;
    logic        resp_seen_p0;
    logic [31:0] rdata_buf_p0;

    logic        ready_go;
    logic        leave;
    logic        buffer_resp;
    logic        allowin;
    logic [31:0] rd;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;
    ms_to_ds_t   ds_out;

    assign es_in = es_to_ms_t'(bus.es_to_ms_bus);

    assign ready_go    = ~bus_p0.mem_req | resp_seen_p0 | bus.data_sram_data_ok;
    assign leave       = vld_p0 & ready_go & bus.ws_allowin;
    // A response that cannot be forwarded this cycle is parked until WB accepts.
    assign buffer_resp = vld_p0 & bus_p0.mem_req & bus.data_sram_data_ok & ~bus.ws_allowin;
    assign allowin     = ~vld_p0 | (ready_go & bus.ws_allowin);

    // ---- stage p0: control state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0       <= 1'b0;
            resp_seen_p0 <= 1'b0;
        end else begin
            if (allowin) begin
                vld_p0 <= bus.es_to_ms_valid;
            end
            if (leave) begin
                resp_seen_p0 <= 1'b0;
            end else if (buffer_resp) begin
                resp_seen_p0 <= 1'b1;
            end
        end
    end

    // ---- stage p0: datapath registers ----
    always_ff @(posedge clk) begin
        if (bus.es_to_ms_valid & allowin) begin
            bus_p0 <= es_in;
        end
        if (buffer_resp) begin
            rdata_buf_p0 <= bus.data_sram_rdata;
        end
    end

    assign rd = resp_seen_p0 ? rdata_buf_p0 : bus.data_sram_rdata;

    mem_stage_load_align u_align (
        .ld_op       (bus_p0.ld_op),
        .offset      (bus_p0.alu_result[1:0]),
        .rd          (rd),
        .load_result (load_result)
    );

    assign final_result = (bus_p0.ld_op != LD_NONE) ? load_result : bus_p0.alu_result;

    always_comb begin
        ws_out.gr_we        = bus_p0.gr_we;
        ws_out.dest         = bus_p0.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = bus_p0.pc;

        ds_out.we_valid     = vld_p0 & bus_p0.gr_we;
        ds_out.dest         = bus_p0.dest;
        ds_out.load_pending = vld_p0 & (bus_p0.ld_op != LD_NONE) & ~ready_go;
        ds_out.final_result = final_result;
    end

    assign bus.ms_allowin     = allowin;
    assign bus.ms_to_ws_valid = vld_p0 & ready_go;
    assign bus.ms_to_ws_bus   = ws_out;
    assign bus.ms_to_ds_bus   = ds_out;

endmodule
